id_stage: RTL

//  Instruction-decode stage; sits directly downstream of the fetch stage. Holds the IF/ID pipeline register,

---
 rtl/id_stage_pkg.sv | 37 +++
 rtl/id_stage_if.sv | 34 +++
 rtl/id_stage_register_file.sv | 53 +++++
 rtl/id_stage.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/id_stage_pkg.sv
// Shared decode constants for the instruction-decode stage: opcodes, ID/EX control
// bit positions, ALUOp codes and the control-word builder.
package id_pkg;

  localparam int REG_AW = 5;
  localparam int CTRL_W = 9;

  typedef logic [CTRL_W-1:0] ctrl_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam int CTRL_REG_DST    = 8;
  localparam int CTRL_ALU_SRC    = 7;
  localparam int CTRL_MEM_TO_REG = 6;
  localparam int CTRL_REG_WRITE  = 5;
  localparam int CTRL_MEM_READ   = 4;
  localparam int CTRL_MEM_WRITE  = 3;
  localparam int CTRL_BRANCH     = 2;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  function automatic ctrl_t make_ctrl(input logic reg_dst, input logic alu_src,
                                      input logic mem_to_reg, input logic reg_write,
                                      input logic mem_read, input logic mem_write,
                                      input logic branch, input logic [1:0] alu_op);
    return {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op};
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch-side and ID/EX-side bundle of the decode stage; master is the decode stage itself.
interface id_stage_if
  import id_pkg::*;
#(
  parameter int XLEN = 32
);
  logic [XLEN-1:0]   if_pc_plus4;
  logic [XLEN-1:0]   if_inst;
  logic              pc_write;
  logic              pc_src;
  logic [XLEN-1:0]   branch_target;
  logic [XLEN-1:0]   idex_pc_plus4;
  logic [XLEN-1:0]   idex_rdata1;
  logic [XLEN-1:0]   idex_rdata2;
  logic [XLEN-1:0]   idex_imm;
  logic [REG_AW-1:0] idex_rs;
  logic [REG_AW-1:0] idex_rt;
  logic [REG_AW-1:0] idex_rd;
  ctrl_t             idex_ctrl;

  modport master (
    input  if_pc_plus4, if_inst,
    output pc_write, pc_src, branch_target,
    output idex_pc_plus4, idex_rdata1, idex_rdata2, idex_imm,
    output idex_rs, idex_rt, idex_rd, idex_ctrl
  );

  modport slave (
    output if_pc_plus4, if_inst,
    input  pc_write, pc_src, branch_target,
    input  idex_pc_plus4, idex_rdata1, idex_rdata2, idex_imm,
    input  idex_rs, idex_rt, idex_rd, idex_ctrl
  );
endinterface

// File: rtl/id_stage_register_file.sv
// 2-read 1-write register file with write-through bypass; register 0 is hardwired to zero.
module register_file #(
  parameter int NREG = 32,
  parameter int XLEN = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs_r [NREG];

  // Storage update; writes to register 0 are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (we && (waddr != {AW{1'b0}})) begin
      regs_r[waddr] <= wdata;
    end
  end

  // Port 1 read: a same-cycle writeback to the read index wins over stored data.
  always_comb begin
    if (raddr1 == {AW{1'b0}}) begin
      rdata1 = {XLEN{1'b0}};
    end else if (we && (waddr == raddr1)) begin
      rdata1 = wdata;
    end else begin
      rdata1 = regs_r[raddr1];
    end
  end

  // Port 2 read, same bypass rule as port 1.
  always_comb begin
    if (raddr2 == {AW{1'b0}}) begin
      rdata2 = {XLEN{1'b0}};
    end else if (we && (waddr == raddr2)) begin
      rdata2 = wdata;
    end else begin
      rdata2 = regs_r[raddr2];
    end
  end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID register, decode, register read, load-use and branch
// hazard detection, beq/bne/j resolution and the ID/EX pipeline register.
module id_stage
  import id_pkg::*;
#(
  parameter int NREG = 32,
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_write_reg,
  input  logic [XLEN-1:0]   wb_write_data,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_write_reg,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_write_reg,
  id_stage_if.master        bus
);

  logic [XLEN-1:0]   ifid_pc_r, ifid_inst_r;
  logic [XLEN-1:0]   idex_pc_r, idex_rdata1_r, idex_rdata2_r, idex_imm_r;
  logic [REG_AW-1:0] idex_rs_r, idex_rt_r, idex_rd_r;
  ctrl_t             idex_ctrl_r;

  logic [5:0]        opcode_s;
  logic [REG_AW-1:0] rs_s, rt_s, rd_s;
  logic [XLEN-1:0]   imm_s, rdata1_s, rdata2_s, target_s;
  ctrl_t             ctrl_s;
  logic              uses_rt_s, is_br_s, is_j_s;
  logic              load_use_s, br_haz_s, stall_s, taken_s;

  assign opcode_s = ifid_inst_r[31:26];
  assign rs_s     = ifid_inst_r[25:21];
  assign rt_s     = ifid_inst_r[20:16];
  assign rd_s     = ifid_inst_r[15:11];
  assign imm_s    = {{(XLEN-16){ifid_inst_r[15]}}, ifid_inst_r[15:0]};

  register_file #(.NREG(NREG), .XLEN(XLEN), .AW(REG_AW)) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_reg_write),
    .waddr  (wb_write_reg),
    .wdata  (wb_write_data),
    .raddr1 (rs_s),
    .raddr2 (rt_s),
    .rdata1 (rdata1_s),
    .rdata2 (rdata2_s)
  );

  // Opcode decode into the ID/EX control word; an all-zero word is a NOP.
  always_comb begin
    ctrl_s    = {CTRL_W{1'b0}};
    uses_rt_s = 1'b0;
    is_br_s   = 1'b0;
    is_j_s    = 1'b0;
    if (ifid_inst_r == {XLEN{1'b0}}) begin
      ctrl_s = {CTRL_W{1'b0}};
    end else begin
      case (opcode_s)
        OP_R: begin
          ctrl_s    = make_ctrl(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALUOP_FUNCT);
          uses_rt_s = 1'b1;
        end
        OP_LW:   ctrl_s = make_ctrl(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ALUOP_ADD);
        OP_SW: begin
          ctrl_s    = make_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALUOP_ADD);
          uses_rt_s = 1'b1;
        end
        OP_BEQ, OP_BNE: begin
          ctrl_s    = make_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_SUB);
          uses_rt_s = 1'b1;
          is_br_s   = 1'b1;
        end
        OP_ADDI: ctrl_s = make_ctrl(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALUOP_ADD);
        OP_J:    is_j_s = 1'b1;
        default: ctrl_s = {CTRL_W{1'b0}};
      endcase
    end
  end

  // Branch operands are not forwarded, so any pending EX/MEM producer of rs/rt stalls.
  always_comb begin
    load_use_s = ex_mem_read && (ex_write_reg != {REG_AW{1'b0}}) &&
                 ((ex_write_reg == rs_s) || ((ex_write_reg == rt_s) && uses_rt_s));
    br_haz_s   = is_br_s &&
                 (((rs_s != {REG_AW{1'b0}}) &&
                   ((ex_reg_write && (ex_write_reg == rs_s)) ||
                    (mem_reg_write && (mem_write_reg == rs_s)))) ||
                  ((rt_s != {REG_AW{1'b0}}) &&
                   ((ex_reg_write && (ex_write_reg == rt_s)) ||
                    (mem_reg_write && (mem_write_reg == rt_s)))));
    stall_s    = load_use_s | br_haz_s;
    if (stall_s) begin
      taken_s = 1'b0;
    end else begin
      taken_s = is_j_s ||
                ((opcode_s == OP_BEQ) && (rdata1_s == rdata2_s)) ||
                ((opcode_s == OP_BNE) && (rdata1_s != rdata2_s));
    end
    if (is_j_s) begin
      target_s = {ifid_pc_r[31:28], ifid_inst_r[25:0], 2'b00};
    end else begin
      target_s = ifid_pc_r + {imm_s[XLEN-3:0], 2'b00};
    end
  end

  assign bus.pc_write      = ~stall_s;
  assign bus.pc_src        = taken_s;
  assign bus.branch_target = target_s;

  // IF/ID register: a taken redirect flushes the fetched slot to a NOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_pc_r   <= {XLEN{1'b0}};
      ifid_inst_r <= {XLEN{1'b0}};
    end else if (stall_s) begin
      ifid_pc_r   <= ifid_pc_r;
      ifid_inst_r <= ifid_inst_r;
    end else if (taken_s) begin
      ifid_pc_r   <= bus.if_pc_plus4;
      ifid_inst_r <= {XLEN{1'b0}};
    end else begin
      ifid_pc_r   <= bus.if_pc_plus4;
      ifid_inst_r <= bus.if_inst;
    end
  end

  // ID/EX register: a stall injects an all-zero bubble.
  always_ff @(posedge clk) begin
    if (rst || stall_s) begin
      idex_pc_r     <= {XLEN{1'b0}};
      idex_rdata1_r <= {XLEN{1'b0}};
      idex_rdata2_r <= {XLEN{1'b0}};
      idex_imm_r    <= {XLEN{1'b0}};
      idex_rs_r     <= {REG_AW{1'b0}};
      idex_rt_r     <= {REG_AW{1'b0}};
      idex_rd_r     <= {REG_AW{1'b0}};
      idex_ctrl_r   <= {CTRL_W{1'b0}};
    end else begin
      idex_pc_r     <= ifid_pc_r;
      idex_rdata1_r <= rdata1_s;
      idex_rdata2_r <= rdata2_s;
      idex_imm_r    <= imm_s;
      idex_rs_r     <= rs_s;
      idex_rt_r     <= rt_s;
      idex_rd_r     <= rd_s;
      idex_ctrl_r   <= ctrl_s;
      if (taken_s) begin
        idex_ctrl_r[CTRL_REG_WRITE] <= 1'b0;
        idex_ctrl_r[CTRL_MEM_WRITE] <= 1'b0;
      end
    end
  end

  assign bus.idex_pc_plus4 = idex_pc_r;
  assign bus.idex_rdata1   = idex_rdata1_r;
  assign bus.idex_rdata2   = idex_rdata2_r;
  assign bus.idex_imm      = idex_imm_r;
  assign bus.idex_rs       = idex_rs_r;
  assign bus.idex_rt       = idex_rt_r;
  assign bus.idex_rd       = idex_rd_r;
  assign bus.idex_ctrl     = idex_ctrl_r;

endmodule
